// File: rtl/pcss_link_tx.sv
// Link transmit stage: splits AXI-stream host words into parity-protected flits
// and rewinds to the flit the chip reports as corrupted.
module pcss_link_tx #(
  parameter int DATA_WIDTH     = 64,
  parameter int CHIPDATA_WIDTH = 16,
  parameter int PAR_ODD        = 0,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     S_AXIS_tdata,
  input  logic                      S_AXIS_tvalid,
  input  logic [DATA_WIDTH/8-1:0]   S_AXIS_tkeep,
  input  logic                      S_AXIS_tlast,
  output logic                      S_AXIS_tready,
  output logic [CHIPDATA_WIDTH-1:0] send_data_out,
  output logic                      send_data_valid,
  output logic                      send_data_par,
  input  logic                      send_data_ready,
  input  logic                      send_data_err,
  output logic [ERR_CNT_W-1:0]      err_cnt,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  localparam int NFLIT = DATA_WIDTH / CHIPDATA_WIDTH;
  localparam int BPF   = CHIPDATA_WIDTH / 8;
  localparam int IDX_W = (NFLIT > 1) ? $clog2(NFLIT) : 1;
  localparam int CNT_W = $clog2(NFLIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     word_q, word_d;
  logic [CNT_W-1:0]          nflit_q, nflit_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      acc_prev_q, acc_prev_d;
  logic [IDX_W-1:0]          idx_prev_q, idx_prev_d;
  logic [ERR_CNT_W-1:0]      err_cnt_q, err_cnt_d;
  logic [CHIPDATA_WIDTH-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      par_q, par_d;
  logic                      tready_q, tready_d;

  logic [CNT_W-1:0]          nflit_in;
  logic                      word_acc;
  logic                      flit_acc;
  logic                      rewind;
  logic                      unused_ok;

  // Both links use strict valid/ready: a transfer happens on the rising edge
  // where valid && ready are both high; valid never waits on ready.
  assign word_acc  = S_AXIS_tvalid && tready_q;
  assign flit_acc  = valid_q && send_data_ready;
  // err refers to the flit accepted one edge earlier, so it needs acc_prev_q.
  assign rewind    = send_data_err && acc_prev_q;
  assign unused_ok = ^{S_AXIS_tlast, S_AXIS_tkeep};

  // Flits are counted only up to the first cleared keep bit.
  always_comb begin
    logic gap;
    nflit_in = '0;
    gap      = 1'b0;
    for (int k = 0; k < NFLIT; k++) begin
      if (!gap && S_AXIS_tkeep[k*BPF]) nflit_in = nflit_in + CNT_W'(1);
      else                             gap      = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    nflit_d    = nflit_q;
    idx_d      = idx_q;
    acc_prev_d = flit_acc;
    idx_prev_d = idx_q;
    err_cnt_d  = err_cnt_q;
    if (send_data_err && (err_cnt_q != {ERR_CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (word_acc && (nflit_in != '0)) begin
          word_d  = S_AXIS_tdata;
          nflit_d = nflit_in;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (rewind) begin
          idx_d = idx_prev_q;
        end else if (flit_acc) begin
          if (CNT_W'(idx_q) == nflit_q - CNT_W'(1)) state_d = ST_HOLD;
          else                                       idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_HOLD: begin
        if (rewind) begin
          idx_d   = idx_prev_q;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Output flops are loaded from next-state so they line up with the FSM.
    data_d   = word_d[idx_d*CHIPDATA_WIDTH +: CHIPDATA_WIDTH];
    par_d    = (PAR_ODD != 0) ? ~^data_d : ^data_d;
    valid_d  = (state_d == ST_SEND);
    tready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      nflit_q    <= '0;
      idx_q      <= '0;
      acc_prev_q <= 1'b0;
      idx_prev_q <= '0;
      err_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      par_q      <= 1'b0;
      tready_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      nflit_q    <= nflit_d;
      idx_q      <= idx_d;
      acc_prev_q <= acc_prev_d;
      idx_prev_q <= idx_prev_d;
      err_cnt_q  <= err_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      par_q      <= par_d;
      tready_q   <= tready_d;
    end
  end

  assign S_AXIS_tready   = tready_q;
  assign send_data_out   = data_q;
  assign send_data_valid = valid_q;
  assign send_data_par   = par_q;
  assign err_cnt         = err_cnt_q;
  assign busy            = (state_q != ST_IDLE);
  assign dbg_state       = state_q;

endmodule
